// File: rtl/fsm_cmd_pkg.sv
// Shared definitions for the command conditioner and the downstream 4-state FSM:
// conditioner state encoding and the 2-bit command codes.
package fsm_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    ISSUE   = 2'd2,
    RELEASE = 2'd3
  } cond_state_t;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_S1   = 2'b01;
  localparam logic [1:0] CMD_S2   = 2'b10;
  localparam logic [1:0] CMD_S3   = 2'b11;

endpackage

// File: rtl/fsm_cmd_conditioner_sync.sv
// Width-parameterised two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/fsm_cmd_conditioner.sv
// Debounces two raw button lines into one single-cycle command per press.
// Optional auto-repeat while held: define CMD_COND_REPEAT_EN.
module fsm_cmd_conditioner
  import fsm_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn_raw,
  output logic [1:0] cmd,
  output logic       cmd_valid,
  output logic       busy
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("fsm_cmd_conditioner: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [1:0]       w_sync;
  cond_state_t      r_state, w_state_nxt;
  logic [1:0]       r_cand,  w_cand_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [1:0]       r_cmd;
  logic             r_cmd_valid;

  sync_2ff #(.WIDTH(2)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (btn_raw),
    .o_q   (w_sync)
  );

`ifdef CMD_COND_REPEAT_EN
  localparam int              RPT_W    = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] r_rpt, w_rpt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rpt <= '0;
    else       r_rpt <= w_rpt_nxt;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
`ifdef CMD_COND_REPEAT_EN
    w_rpt_nxt   = '0;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_sync != CMD_HOLD) begin
          w_state_nxt = SETTLE;
          w_cand_nxt  = w_sync;
          w_cnt_nxt   = '0;
        end
      end
      SETTLE: begin
        if (w_sync == CMD_HOLD) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (w_sync != r_cand) begin
          w_cand_nxt = w_sync;
          w_cnt_nxt  = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ISSUE;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      ISSUE: begin
        w_state_nxt = RELEASE;
        w_cnt_nxt   = '0;
      end
      RELEASE: begin
        // Any nonzero level restarts the zero-run, absorbing release bounce.
        if (w_sync != CMD_HOLD) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
`ifdef CMD_COND_REPEAT_EN
        if (w_sync == r_cand) begin
          if (r_rpt == RPT_LAST) w_state_nxt = ISSUE;
          else                   w_rpt_nxt   = r_rpt + 1'b1;
        end
`endif
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cand      <= CMD_HOLD;
      r_cnt       <= '0;
      r_cmd       <= CMD_HOLD;
      r_cmd_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_cnt       <= w_cnt_nxt;
      // Registered so the FSM sees a glitch-free code aligned with ISSUE.
      r_cmd       <= (w_state_nxt == ISSUE) ? w_cand_nxt : CMD_HOLD;
      r_cmd_valid <= (w_state_nxt == ISSUE);
    end
  end

  assign cmd       = r_cmd;
  assign cmd_valid = r_cmd_valid;
  assign busy      = (r_state != IDLE);

endmodule

// File: doc/fsm_cmd_conditioner.md
Name: fsm_cmd_conditioner

Overview:
Upstream stage of the 4-state control FSM. It conditions two raw, asynchronous push-button/switch lines into a clean 2-bit command code that the FSM samples every clock.
- Synchronises and debounces the inputs.
- Issues exactly one single-cycle non-idle code per press.
- Drives 2'b00 (hold/idle) at all other times, so the downstream FSM never sees bounce or glitch codes.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised cycles required to accept a level; legal range >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES)+1: debounce counter width; derived, not overridden.
- REPEAT_CYCLES, 1000: auto-repeat interval in cycles; only used with CMD_COND_REPEAT_EN.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- btn_raw, input, 2: raw asynchronous button levels; bit1 = MSB of code.
- cmd, output, 2: conditioned command to the FSM; 2'b00 except during an issue cycle.
- cmd_valid, output, 1: high for exactly the cycle in which cmd is non-idle.
- busy, output, 1: high whenever state != IDLE.

Behaviour:
- Reset is asynchronous, active-high, on clock clk. Reset values: cmd=2'b00, cmd_valid=0, busy=0, state=IDLE, counter=0, candidate=2'b00, both synchroniser stages=2'b00.
- Synchroniser: 2-flop on both bits; sync = second stage. All decisions use sync only.
- States are IDLE, SETTLE, ISSUE and RELEASE.
- IDLE:
  - sync==00: stay.
  - sync!=00: go to SETTLE, latch cand=sync, cnt=0.
- SETTLE:
  - sync==00: go to IDLE.
  - sync!=cand (nonzero): stay, cand=sync, cnt=0 (restart).
  - sync==cand and cnt==DEBOUNCE_CYCLES-1: go to ISSUE.
  - Otherwise cnt++.
- ISSUE (exactly 1 cycle):
  - cmd=cand, cmd_valid=1. cmd/cmd_valid come from flops loaded on the edge entering ISSUE.
  - Next state is RELEASE with cnt=0, unconditionally.
- RELEASE:
  - cmd=00.
  - sync!=00: cnt=0, stay.
  - sync==00 with cnt==DEBOUNCE_CYCLES-1: go to IDLE.
  - Otherwise cnt++.
  - A code change while held never issues a second command.
- Latency: raw level stable before edge 0 → cmd_valid high in the cycle after edge DEBOUNCE_CYCLES+2 (2 sync edges, 1 IDLE→SETTLE edge, DEBOUNCE_CYCLES-1 count edges, 1 issue edge).
- Release requires DEBOUNCE_CYCLES stable-zero cycles before a new press is accepted. Bounce on release is therefore absorbed.
- Width: cnt saturates, never wraps. The compare uses CNT_W-bit unsigned arithmetic.
- Reset mid-operation (any state, including ISSUE): outputs drop to reset values immediately (asynchronous); no pending command survives.
- One-cycle glitches on btn_raw shorter than DEBOUNCE_CYCLES never produce cmd_valid.

Optional Feature:
- Macro: CMD_COND_REPEAT_EN.
- Defined: in RELEASE, if sync==cand continuously, a second counter counts. On reaching REPEAT_CYCLES-1 the block returns to ISSUE (one-cycle re-issue of cand) and the repeat counter clears. The counter clears on any sync change.
- Undefined: no repeat counter is synthesised; one issue per press, exactly as above.

Decomposition:
- Shared package fsm_cmd_pkg holds:
  - conditioner state enum (IDLE, SETTLE, ISSUE, RELEASE);
  - command code constants CMD_HOLD=2'b00, CMD_S1=2'b01, CMD_S2=2'b10, CMD_S3=2'b11, reused by the downstream FSM.
- One sub-module: sync_2ff, a width-parameterised two-flop synchroniser, instantiated with WIDTH=2.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean press: btn_raw=01 held 20 cycles, then 00 → cmd=01 with cmd_valid=1 for exactly 1 cycle, after edge 6; cmd=00 otherwise; busy returns low 4 cycles after the sync sees 00.
- Bounce: btn_raw toggles 10/00 every 2 cycles for 12 cycles, then 10 held 10 cycles → single issue of 10, only after the stable period; no earlier cmd_valid.
- Candidate change: btn_raw=01 for 3 cycles, then 11 held → counter restarts; exactly one issue, of 11; 01 never issued.
- Held input: btn_raw=11 held 200 cycles (macro undefined) → exactly one cmd_valid. Same with CMD_COND_REPEAT_EN, REPEAT_CYCLES=50 → issues of 11 spaced 51 cycles apart.
- Reset mid-operation: assert reset asynchronously during SETTLE and again on the ISSUE cycle → cmd=00, cmd_valid=0, busy=0 immediately; with btn_raw=00 after release, no command is issued.
- Release bounce: after an issue, btn_raw toggles 01/00 every cycle for 6 cycles → no further cmd_valid; IDLE is entered only after 4 consecutive zero cycles.
